pin_conditioner: RTL

PIN_CONDITIONER -- requirements
Module: pin_conditioner

---
 rtl/pin_conditioner.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pin_conditioner.sv
// ---------------------------------------------------------------------------
// pin_conditioner
//
// Conditions eight asynchronous external pins for use by the CPU:
// each pin is synchronised through two flops and then debounced by a
// per-pin counter against a programmable threshold (FILT). Rising and
// falling transitions of the debounced level can latch sticky flags
// that drive a level interrupt.
//
// Register block (CPU I/O bus, byte wide, at BASE_ADDRESS):
//   BASE+0  RISE_EN  R/W   per-pin enable: flag on debounced 0->1
//   BASE+1  FALL_EN  R/W   per-pin enable: flag on debounced 1->0
//   BASE+2  FLAGS    R/W1C sticky transition flags
//   BASE+3  FILT     R/W   debounce threshold in clk cycles
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   din         write data from the CPU bus
//   address     I/O address
//   w_en        write strobe, sampled on clk
//   r_en        read strobe, sampled on clk
//   dout        registered read data
//   pins_raw    asynchronous external pin levels
//   pins_clean  synchronised, debounced pin levels
//   irq         high while any FLAGS bit is set
//
// Bus handshake: there is no valid/ready pair. A strobe that is high at a
// rising edge is a complete transfer on that edge; the target never
// stalls. Writes take effect on that edge; read data is on dout from that
// edge until the next read. A read and write of the same register on the
// same edge returns the old value and stores the new one.
// ---------------------------------------------------------------------------
module pin_conditioner #(
   parameter logic [7:0] BASE_ADDRESS = 8'h04
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic [7:0] address,
   input  logic       w_en,
   input  logic       r_en,
   output logic [7:0] dout,
   input  logic [7:0] pins_raw,
   output logic [7:0] pins_clean,
   output logic       irq
);

   localparam logic [7:0] ADDR_RISE_EN = BASE_ADDRESS;
   localparam logic [7:0] ADDR_FALL_EN = BASE_ADDRESS + 8'd1;
   localparam logic [7:0] ADDR_FLAGS   = BASE_ADDRESS + 8'd2;
   localparam logic [7:0] ADDR_FILT    = BASE_ADDRESS + 8'd3;

   logic [7:0] s1;
   logic [7:0] s2;
   logic [7:0] clean;
   logic [7:0] clean_q;   // clean delayed one edge, for transition detect
   logic [7:0] cnt [8];
   logic [7:0] rise_en;
   logic [7:0] fall_en;
   logic [7:0] flags;
   logic [7:0] filt;

   logic       sel_rise_en;
   logic       sel_fall_en;
   logic       sel_flags;
   logic       sel_filt;
   logic [7:0] rd_data;
   logic [7:0] flags_set;
   logic [7:0] flags_nxt;

   // ---------------- address decode and read mux ----------------
   always_comb begin
      sel_rise_en = (address == ADDR_RISE_EN);
      sel_fall_en = (address == ADDR_FALL_EN);
      sel_flags   = (address == ADDR_FLAGS);
      sel_filt    = (address == ADDR_FILT);

      rd_data = 8'h00;
      if (sel_rise_en)      rd_data = rise_en;
      else if (sel_fall_en) rd_data = fall_en;
      else if (sel_flags)   rd_data = flags;
      else if (sel_filt)    rd_data = filt;
   end

   // ---------------- two-flop synchroniser ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 8'h00;
         s2 <= 8'h00;
      end else begin
         s1 <= pins_raw;
         s2 <= s1;
      end
   end

   // ---------------- per-pin debounce ----------------
   // The counter only advances while cnt < filt, so it tops out at 255
   // and cannot wrap. The live filt register is compared every edge, so a
   // lowered threshold releases a pending pin on the next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clean   <= 8'h00;
         clean_q <= 8'h00;
         for (int i = 0; i < 8; i++) cnt[i] <= 8'h00;
      end else begin
         clean_q <= clean;
         for (int i = 0; i < 8; i++) begin
            if (s2[i] == clean[i]) begin
               cnt[i] <= 8'h00;
            end else if (cnt[i] >= filt) begin
               clean[i] <= s2[i];
               cnt[i]   <= 8'h00;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   // ---------------- flag update ----------------
   // A debounced transition seen between clean_q and clean sets its flag
   // on the edge after clean changed. The set term is applied after the
   // write-1-to-clear term so a coinciding set wins.
   always_comb begin
      flags_set = (clean & ~clean_q & rise_en) | (~clean & clean_q & fall_en);
      flags_nxt = flags;
      if (w_en && sel_flags) flags_nxt = flags & ~din;
      flags_nxt = flags_nxt | flags_set;
   end

   // ---------------- registers and read data ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_en <= 8'h00;
         fall_en <= 8'h00;
         flags   <= 8'h00;
         filt    <= 8'h00;
         dout    <= 8'h00;
      end else begin
         flags <= flags_nxt;
         if (w_en && sel_rise_en) rise_en <= din;
         if (w_en && sel_fall_en) fall_en <= din;
         if (w_en && sel_filt)    filt    <= din;
         // rd_data is built from pre-edge register values, so a same-edge
         // write is never visible in this read.
         if (r_en) dout <= rd_data;
      end
   end

   assign pins_clean = clean;
   // flags is a register, so irq has no combinational path from the bus.
   assign irq        = |flags;

endmodule
